// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and encodings for the pipeline hazard controller
//
// Purpose : operand-source select encodings, default register-number width,
//           the per-stage shadow entry and a stage-to-select helper used by
//           pipe_hazard_ctrl and hazard_src_cmp.
// Ports   : none (package).
package pipe_pkg;

  localparam int REG_AW_DEF = 5;

  // Widest register number a shadow entry can hold. Narrower register
  // numbers are zero-extended into it, so REG_AW must not exceed RN_W.
  localparam int RN_W = 8;

  localparam logic [1:0] FWD_RF  = 2'b00;  // register file
  localparam logic [1:0] FWD_EX  = 2'b01;  // EX ALU result
  localparam logic [1:0] FWD_MEM = 2'b10;  // MEM ALU result
  localparam logic [1:0] FWD_LD  = 2'b11;  // MEM load data

  typedef struct packed {
    logic            wreg;
    logic            m2reg;
    logic [RN_W-1:0] rn;
  } shadow_t;

  typedef enum logic [1:0] {
    ST_EX  = 2'd0,
    ST_MEM = 2'd1,
    ST_WB  = 2'd2
  } stage_e;

  // Operand source for a producer found in stage st. A WB producer is read
  // straight from the regfile because the write lands before the read.
  function automatic logic [1:0] fwd_for_stage(input stage_e st, input logic is_load);
    case (st)
      ST_EX:   fwd_for_stage = FWD_EX;
      ST_MEM:  fwd_for_stage = is_load ? FWD_LD : FWD_MEM;
      default: fwd_for_stage = FWD_RF;
    endcase
  endfunction

endpackage

// File: rtl/hazard_src_cmp.sv
// rtl/hazard_src_cmp.sv - per-source dependence check against the EX/MEM/WB shadows
//
// Purpose : decides, for one source operand of the ID instruction, where its
//           value comes from and whether ID must stall for it.
// Macro   : PIPE_FWD_EN - when defined, forwarding selects are produced and
//           only load-use stalls; otherwise fwd is 00 and any EX/MEM
//           dependence stalls.
// Ports   : src, src_used   - source register number and its read flag
//           ex, mem, wb     - shadow entries of the later stages
//           fwd             - operand-source select
//           stall_req       - this source needs ID held this cycle
module hazard_src_cmp
  import pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] src,
  input  logic              src_used,
  input  shadow_t           ex,
  input  shadow_t           mem,
  input  shadow_t           wb,
  output logic [1:0]        fwd,
  output logic              stall_req
);

  logic [RN_W-1:0] src_w;
  logic            ex_hit;
  logic            mem_hit;

  assign src_w = RN_W'(src);

  // r0 is hard-wired zero, so a producer targeting it never creates a dependence.
  assign ex_hit  = src_used & ex.wreg  & (ex.rn  != '0) & (ex.rn  == src_w);
  assign mem_hit = src_used & mem.wreg & (mem.rn != '0) & (mem.rn == src_w);

`ifdef PIPE_FWD_EN
  logic wb_hit;

  assign wb_hit = src_used & wb.wreg & (wb.rn != '0) & (wb.rn == src_w);

  // Youngest producer wins: EX beats MEM beats WB.
  always_comb begin
    fwd = FWD_RF;
    if (ex_hit)       fwd = fwd_for_stage(ST_EX, ex.m2reg);
    else if (mem_hit) fwd = fwd_for_stage(ST_MEM, mem.m2reg);
    else if (wb_hit)  fwd = fwd_for_stage(ST_WB, wb.m2reg);
  end

  // Load data is not available until the end of MEM.
  assign stall_req = ex_hit & ex.m2reg;
`else
  assign fwd       = FWD_RF;
  assign stall_req = ex_hit | mem_hit;
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall, bubble, flush and forwarding control for a 5-stage pipeline
//
// Purpose : tracks {wreg, m2reg, rn} of the instructions in EX, MEM and WB and
//           compares them against the ID instruction's sources.
// Macro   : PIPE_FWD_EN - enables operand forwarding (see hazard_src_cmp).
// Ports   : clk, clr                    - clock, async active-high reset
//           id_rs/id_rt, *_used         - ID source registers and read flags
//           id_wreg, id_m2reg, id_rn    - ID writeback/load flags, destination
//           id_branch, id_jump, br_taken- control-transfer info of ID
//           stall, bubble, flush        - pipeline control (combinational)
//           fwda, fwdb                  - operand-source selects (combinational)
//           stall_cnt                   - saturating count of stall cycles
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_wreg,
  input  logic              id_m2reg,
  input  logic [REG_AW-1:0] id_rn,
  input  logic              id_branch,
  input  logic              id_jump,
  input  logic              br_taken,
  output logic              stall,
  output logic              bubble,
  output logic              flush,
  output logic [1:0]        fwda,
  output logic [1:0]        fwdb,
  output logic [15:0]       stall_cnt
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  shadow_t    id_entry;
  shadow_t    ex_q;
  shadow_t    mem_q;
  shadow_t    wb_q;
  logic [1:0] fwd_rs;
  logic [1:0] fwd_rt;
  logic       req_rs;
  logic       req_rt;
  logic       hazard;
  logic       redirect;

  always_comb begin
    id_entry       = '0;
    id_entry.wreg  = id_wreg;
    id_entry.m2reg = id_m2reg;
    id_entry.rn    = RN_W'(id_rn);
  end

  hazard_src_cmp #(.REG_AW(REG_AW)) u_cmp_rs (
    .src       (id_rs),
    .src_used  (id_rs_used),
    .ex        (ex_q),
    .mem       (mem_q),
    .wb        (wb_q),
    .fwd       (fwd_rs),
    .stall_req (req_rs)
  );

  hazard_src_cmp #(.REG_AW(REG_AW)) u_cmp_rt (
    .src       (id_rt),
    .src_used  (id_rt_used),
    .ex        (ex_q),
    .mem       (mem_q),
    .wb        (wb_q),
    .fwd       (fwd_rt),
    .stall_req (req_rt)
  );

  assign hazard   = req_rs | req_rt;
  assign redirect = (id_branch & br_taken) | id_jump;

  // A stalled branch keeps IF/ID alive; it redirects once its operands are ready.
  assign stall  = ~clr & hazard;
  assign bubble = stall;
  assign flush  = ~clr & ~hazard & redirect;
  assign fwda   = clr ? FWD_RF : fwd_rs;
  assign fwdb   = clr ? FWD_RF : fwd_rt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
    end else begin
      ex_q  <= bubble ? '0 : id_entry;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (stall && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule
